// File: rtl/gomoku_turn_ctrl_if.sv
// Judger / board-RAM / board-clear handshake bundle for gomoku_turn_ctrl.
// master = game-flow controller, slave = judger, RAM and clear engine.
interface gomoku_turn_ctrl_if #(
  parameter int EDGE_BITS = 3
);
  logic                   memrst_en;
  logic                   memrst_done;
  logic                   judge_start;
  logic                   judge_done;
  logic [1:0]             judge_result;
  logic                   ram_we;
  logic [2*EDGE_BITS-1:0] ram_wr_addr;
  logic [1:0]             ram_wr_data;

  modport master (
    output memrst_en, judge_start, ram_we, ram_wr_addr, ram_wr_data,
    input  memrst_done, judge_done, judge_result
  );

  modport slave (
    input  memrst_en, judge_start, ram_we, ram_wr_addr, ram_wr_data,
    output memrst_done, judge_done, judge_result
  );
endinterface

// File: rtl/gomoku_turn_ctrl.sv
// Game-flow controller for N x N two-player connection games.
// Define GOMOKU_UNDO_EN to build in the one-level move undo.
module gomoku_turn_ctrl #(
  parameter int EDGE_BITS   = 3,
  parameter int TURN_SECS_H = 2,
  parameter int TURN_SECS_L = 5,
  parameter int START_TICKS = 2,
  parameter int WIN_MAX     = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_power,
  input  logic                   btn_reset,
  input  logic                   btn_ok,
  input  logic                   btn_undo,
  input  logic                   key_valid,
  input  logic [EDGE_BITS:0]     key_index,
  output logic                   key_received,
  input  logic                   flicker_tick,
  input  logic                   sec_tick,
  gomoku_turn_ctrl_if.master     bus,
  output logic [2:0]             state_o,
  output logic                   active_side,
  output logic [2*EDGE_BITS-1:0] pos,
  output logic                   pos_valid,
  output logic [3:0]             cnt_h,
  output logic [3:0]             cnt_l,
  output logic                   game_draw,
  output logic [3:0]             red_wins,
  output logic [3:0]             green_wins
);
  localparam int             EB      = EDGE_BITS;
  localparam int             CW      = 2*EB + 1;
  localparam logic [CW-1:0]  CELLS   = CW'(1) << (2*EB);
  localparam logic [3:0]     RELOADH = 4'(TURN_SECS_H);
  localparam logic [3:0]     RELOADL = 4'(TURN_SECS_L);
  localparam logic [3:0]     WMAX    = 4'(WIN_MAX);
  localparam logic [7:0]     ST_LAST = 8'(START_TICKS - 1);

  typedef enum logic [2:0] {
    STOPPED  = 3'd0,
    STARTING = 3'd1,
    RESET    = 3'd2,
    WAIT     = 3'd3,
    JUDGE    = 3'd4,
    END      = 3'd5,
    UNDO     = 3'd6
  } state_t;

  state_t          state;
  logic [2:0]      ok_sync;
  logic [EB-1:0]   x_pos, y_pos;
  logic            x_pressed, y_pressed;
  logic [CW-1:0]   piece_cnt;
  logic [7:0]      tick_cnt;
  logic            judge_issued;
  logic            ok_rise, timeout, undo_req;

  assign state_o       = state;
  assign pos           = {y_pos, x_pos};
  assign pos_valid     = x_pressed & y_pressed;
  assign bus.memrst_en = (state == RESET);
  assign ok_rise       = ok_sync[1] & ~ok_sync[2];
  assign timeout       = sec_tick && (cnt_h == 4'd0) && (cnt_l == 4'd0);

`ifdef GOMOKU_UNDO_EN
  logic [2:0]      undo_sync;
  logic            undo_avail;
  logic [2*EB-1:0] last_pos;
  logic            last_side;
  assign undo_req = undo_sync[1] & ~undo_sync[2] & undo_avail;
`else
  logic unused_btn_undo;
  assign unused_btn_undo = btn_undo;
  assign undo_req        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= STOPPED;
      ok_sync          <= '0;
      x_pos            <= '0;
      y_pos            <= '0;
      x_pressed        <= 1'b0;
      y_pressed        <= 1'b0;
      piece_cnt        <= '0;
      tick_cnt         <= '0;
      judge_issued     <= 1'b0;
      key_received     <= 1'b0;
      active_side      <= 1'b0;
      cnt_h            <= RELOADH;
      cnt_l            <= RELOADL;
      game_draw        <= 1'b0;
      red_wins         <= '0;
      green_wins       <= '0;
      bus.judge_start  <= 1'b0;
      bus.ram_we       <= 1'b0;
      bus.ram_wr_addr  <= '0;
      bus.ram_wr_data  <= '0;
`ifdef GOMOKU_UNDO_EN
      undo_sync        <= '0;
      undo_avail       <= 1'b0;
      last_pos         <= '0;
      last_side        <= 1'b0;
`endif
    end else begin
      ok_sync         <= {ok_sync[1:0], btn_ok};
      key_received    <= key_valid;
      bus.judge_start <= 1'b0;
      bus.ram_we      <= 1'b0;
`ifdef GOMOKU_UNDO_EN
      undo_sync       <= {undo_sync[1:0], btn_undo};
`endif
      if (!sw_power) begin
        state      <= STOPPED;
        red_wins   <= '0;
        green_wins <= '0;
        x_pressed  <= 1'b0;
        y_pressed  <= 1'b0;
      end else if (btn_reset) begin
        state <= RESET;
      end else begin
        case (state)
          STOPPED: begin
            state    <= STARTING;
            tick_cnt <= '0;
          end
          STARTING: begin
            if (flicker_tick) begin
              if (tick_cnt >= ST_LAST) state <= RESET;
              else                     tick_cnt <= tick_cnt + 8'd1;
            end
          end
          RESET: begin
            active_side <= 1'b0;
            piece_cnt   <= '0;
            x_pressed   <= 1'b0;
            y_pressed   <= 1'b0;
            game_draw   <= 1'b0;
`ifdef GOMOKU_UNDO_EN
            undo_avail  <= 1'b0;
`endif
            if (bus.memrst_done) state <= WAIT;
          end
          WAIT: begin
            // A commit freezes pos: a key arriving in the same cycle is dropped.
            if ((ok_rise || timeout) && pos_valid) begin
              state        <= JUDGE;
              judge_issued <= 1'b0;
            end else if (undo_req) begin
              state <= UNDO;
            end else if (timeout) begin
              active_side <= ~active_side;
              x_pressed   <= 1'b0;
              y_pressed   <= 1'b0;
              cnt_h       <= RELOADH;
              cnt_l       <= RELOADL;
            end else begin
              if (sec_tick) begin
                if (cnt_l == 4'd0) begin
                  cnt_l <= 4'd9;
                  cnt_h <= cnt_h - 4'd1;
                end else begin
                  cnt_l <= cnt_l - 4'd1;
                end
              end
              if (key_valid) begin
                if (key_index[EB]) begin
                  x_pos     <= key_index[EB-1:0];
                  x_pressed <= 1'b1;
                end else begin
                  y_pos     <= key_index[EB-1:0];
                  y_pressed <= 1'b1;
                end
              end
            end
          end
          JUDGE: begin
            if (!judge_issued) begin
              bus.judge_start <= 1'b1;
              judge_issued    <= 1'b1;
            end else if (bus.judge_done) begin
              x_pressed       <= 1'b0;
              y_pressed       <= 1'b0;
              bus.ram_wr_addr <= {y_pos, x_pos};
              bus.ram_wr_data <= active_side ? 2'b10 : 2'b01;
              if (bus.judge_result == 2'd2) begin
                bus.ram_we <= 1'b1;
                state      <= END;
                if (active_side) green_wins <= (green_wins >= WMAX) ? WMAX : green_wins + 4'd1;
                else             red_wins   <= (red_wins   >= WMAX) ? WMAX : red_wins   + 4'd1;
              end else if (bus.judge_result == 2'd1) begin
                bus.ram_we <= 1'b1;
                piece_cnt  <= piece_cnt + CW'(1);
`ifdef GOMOKU_UNDO_EN
                undo_avail <= 1'b1;
                last_pos   <= {y_pos, x_pos};
                last_side  <= active_side;
`endif
                if (piece_cnt + CW'(1) == CELLS) begin
                  game_draw <= 1'b1;
                  state     <= END;
                end else begin
                  active_side <= ~active_side;
                  state       <= WAIT;
                end
              end else begin
                active_side <= ~active_side;
                state       <= WAIT;
              end
            end
          end
          END: state <= END;
`ifdef GOMOKU_UNDO_EN
          UNDO: begin
            bus.ram_we      <= 1'b1;
            bus.ram_wr_addr <= last_pos;
            bus.ram_wr_data <= 2'b00;
            active_side     <= last_side;
            piece_cnt       <= piece_cnt - CW'(1);
            x_pressed       <= 1'b0;
            y_pressed       <= 1'b0;
            undo_avail      <= 1'b0;
            state           <= WAIT;
          end
`endif
          default: state <= STOPPED;
        endcase
      end
      // Outside WAIT the countdown is parked at its reload value.
      if (state != WAIT || !sw_power) begin
        cnt_h <= RELOADH;
        cnt_l <= RELOADL;
      end
    end
  end
endmodule

// File: tb/tb_gomoku_turn_ctrl.sv
// Scoreboard bench for gomoku_turn_ctrl: an 8x8 instance for play/timeout/tally
// and a 2x2 instance sharing the stimulus for the board-full draw.
module tb_gomoku_turn_ctrl;
  logic clk = 1'b0, rst = 1'b1, sw_power = 1'b0, btn_reset = 1'b0;
  logic btn_ok = 1'b0, btn_undo = 1'b0, key_valid = 1'b0;
  logic flicker_tick = 1'b0, sec_tick = 1'b0;
  logic memrst_done = 1'b0, judge_done = 1'b0;
  logic [1:0] judge_result = 2'd0;
  logic [3:0] key_index = 4'd0;
  logic [1:0] key_index2;

  logic       key_received, active_side, pos_valid, game_draw;
  logic [2:0] state_o;
  logic [5:0] pos;
  logic [3:0] cnt_h, cnt_l, red_wins, green_wins;

  logic       key_received2, active_side2, pos_valid2, game_draw2;
  logic [2:0] state2;
  logic [1:0] pos2;
  logic [3:0] cnt_h2, cnt_l2, red_wins2, green_wins2;

  int passCount = 0, checkCount = 0;
  int jsExpected = 0, jsSeen = 0;
  logic modelSide = 1'b0;
  bit chk2 = 1'b0;
  logic [7:0] q1[$];
  logic [3:0] q2[$];

  gomoku_turn_ctrl_if #(.EDGE_BITS(3)) bus1();
  gomoku_turn_ctrl_if #(.EDGE_BITS(1)) bus2();

  assign key_index2        = {key_index[3], key_index[0]};
  assign bus1.memrst_done  = memrst_done;
  assign bus1.judge_done   = judge_done;
  assign bus1.judge_result = judge_result;
  assign bus2.memrst_done  = memrst_done;
  assign bus2.judge_done   = judge_done;
  assign bus2.judge_result = judge_result;

  gomoku_turn_ctrl #(.EDGE_BITS(3)) dut (
    .clk(clk), .rst(rst), .sw_power(sw_power), .btn_reset(btn_reset),
    .btn_ok(btn_ok), .btn_undo(btn_undo), .key_valid(key_valid),
    .key_index(key_index), .key_received(key_received),
    .flicker_tick(flicker_tick), .sec_tick(sec_tick), .bus(bus1.master),
    .state_o(state_o), .active_side(active_side), .pos(pos),
    .pos_valid(pos_valid), .cnt_h(cnt_h), .cnt_l(cnt_l),
    .game_draw(game_draw), .red_wins(red_wins), .green_wins(green_wins)
  );

  gomoku_turn_ctrl #(.EDGE_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .sw_power(sw_power), .btn_reset(btn_reset),
    .btn_ok(btn_ok), .btn_undo(btn_undo), .key_valid(key_valid),
    .key_index(key_index2), .key_received(key_received2),
    .flicker_tick(flicker_tick), .sec_tick(sec_tick), .bus(bus2.master),
    .state_o(state2), .active_side(active_side2), .pos(pos2),
    .pos_valid(pos_valid2), .cnt_h(cnt_h2), .cnt_l(cnt_l2),
    .game_draw(game_draw2), .red_wins(red_wins2), .green_wins(green_wins2)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Scoreboard drains: every board write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus1.judge_start) jsSeen++;
    if (bus1.ram_we) begin
      if (q1.size() == 0) checkOutput("ram_we_unexpected", {bus1.ram_wr_addr, bus1.ram_wr_data}, 32'hFFFF);
      else checkOutput("ram_write", {bus1.ram_wr_addr, bus1.ram_wr_data}, q1.pop_front());
    end
    if (chk2 && bus2.ram_we) begin
      if (q2.size() == 0) checkOutput("ram_we2_unexpected", {bus2.ram_wr_addr, bus2.ram_wr_data}, 32'hFFFF);
      else checkOutput("ram_write2", {bus2.ram_wr_addr, bus2.ram_wr_data}, q2.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bootUp();
    sw_power = 1'b1;
    tick(2);
    checkOutput("starting_state", state_o, 32'd1);
    flicker_tick = 1'b1; tick(1); flicker_tick = 1'b0; tick(1);
    checkOutput("starting_after_1_tick", state_o, 32'd1);
    flicker_tick = 1'b1; tick(1); flicker_tick = 1'b0;
    checkOutput("reset_state", state_o, 32'd2);
    checkOutput("memrst_en", bus1.memrst_en, 32'd1);
    memrst_done = 1'b1; tick(1); memrst_done = 1'b0;
    checkOutput("wait_state", state_o, 32'd3);
    modelSide = 1'b0;
  endtask

  task automatic restartGame();
    btn_reset = 1'b1;
    tick(2);
    checkOutput("btn_reset_state", state_o, 32'd2);
    btn_reset = 1'b0;
    memrst_done = 1'b1; tick(1); memrst_done = 1'b0;
    modelSide = 1'b0;
  endtask

  // Enter x then y, commit, answer the judger with result r.
  task automatic applyStimulus(input int x, input int y, input int r);
    logic [2:0] xs, ys;
    logic [1:0] data;
    bit seen;
    xs = x[2:0];
    ys = y[2:0];
    key_valid = 1'b1;
    key_index = {1'b1, xs};
    tick(1);
    key_index = {1'b0, ys};
    tick(1);
    key_valid = 1'b0;
    checkOutput("pos_valid", pos_valid, 32'd1);
    checkOutput("pos", pos, {ys, xs});
    btn_ok = 1'b1;
    jsExpected++;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (bus1.judge_start) seen = 1'b1;
    end
    if (!seen) checkOutput("judge_start_timeout", 32'd0, 32'd1);
    data = modelSide ? 2'b10 : 2'b01;
    if (r != 0) begin
      q1.push_back({ys, xs, data});
      if (chk2) q2.push_back({ys[0], xs[0], data});
    end
    judge_done = 1'b1;
    judge_result = r[1:0];
    tick(1);
    judge_done = 1'b0;
    btn_ok = 1'b0;
    tick(4);
    if (r != 2) modelSide = ~modelSide;
  endtask

  initial begin
    tick(3);
    checkOutput("rst_state", state_o, 32'd0);
    checkOutput("rst_cnt", {cnt_h, cnt_l}, 32'h25);
    checkOutput("rst_wins", {red_wins, green_wins}, 32'h0);
    checkOutput("rst_side", active_side, 32'd0);
    checkOutput("rst_ram_we", bus1.ram_we, 32'd0);
    rst = 1'b0;
    tick(2);
    checkOutput("stopped_without_power", state_o, 32'd0);

    bootUp();
    checkOutput("boot_side", active_side, 32'd0);
    checkOutput("boot_cnt", {cnt_h, cnt_l}, 32'h25);

    // Red plays (3,5): write 0x2B with red, turn passes to green.
    applyStimulus(3, 5, 1);
    checkOutput("side_after_valid", active_side, 32'd1);
    checkOutput("cnt_after_valid", {cnt_h, cnt_l}, 32'h25);
    checkOutput("keys_cleared", pos_valid, 32'd0);

    // Green idles through the full countdown and loses the turn.
    for (int i = 1; i <= 26; i++) begin
      sec_tick = 1'b1; tick(1); sec_tick = 1'b0; tick(1);
      if (i == 6)  checkOutput("cnt_borrow", {cnt_h, cnt_l}, 32'h19);
      if (i == 25) begin
        checkOutput("cnt_zero", {cnt_h, cnt_l}, 32'h00);
        checkOutput("side_before_timeout", active_side, 32'd1);
      end
    end
    checkOutput("side_after_timeout", active_side, 32'd0);
    checkOutput("cnt_after_timeout", {cnt_h, cnt_l}, 32'h25);
    checkOutput("judge_starts_so_far", jsSeen, jsExpected);
    modelSide = 1'b0;

    // Invalid move: no write, turn forfeited.
    applyStimulus(0, 0, 0);
    checkOutput("side_after_invalid", active_side, 32'd1);
    checkOutput("state_after_invalid", state_o, 32'd3);

    // Four valid moves fill the 2x2 board.
    restartGame();
    chk2 = 1'b1;
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 1, 1);
    applyStimulus(1, 1, 1);
    chk2 = 1'b0;
    checkOutput("draw2_flag", game_draw2, 32'd1);
    checkOutput("draw2_state", state2, 32'd5);
    checkOutput("draw2_wins", {red_wins2, green_wins2}, 32'h0);
    checkOutput("draw2_queue_empty", q2.size(), 32'd0);
    checkOutput("big_board_no_draw", game_draw, 32'd0);
    checkOutput("big_board_state", state_o, 32'd3);

    // Green wins ten games; tally saturates at 9.
    for (int i = 0; i < 10; i++) begin
      restartGame();
      applyStimulus(1, 1, 0);
      applyStimulus(2, 4, 2);
      checkOutput("green_wins", green_wins, (i + 1 > 9) ? 32'd9 : 32'(i + 1));
    end
    checkOutput("win_state_end", state_o, 32'd5);
    checkOutput("red_wins_unchanged", red_wins, 32'd0);
    tick(3);
    checkOutput("end_holds", state_o, 32'd5);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_state", state_o, 32'd0);
    checkOutput("async_rst_wins", green_wins, 32'd0);
    tick(1);
    rst = 1'b0;

    // Power-off clears the tally.
    bootUp();
    applyStimulus(0, 0, 0);
    applyStimulus(2, 4, 2);
    checkOutput("win_before_poweroff", green_wins, 32'd1);
    sw_power = 1'b0;
    tick(1);
    checkOutput("poweroff_state", state_o, 32'd0);
    checkOutput("poweroff_wins", green_wins, 32'd0);

`ifdef GOMOKU_UNDO_EN
    bootUp();
    applyStimulus(3, 5, 1);
    checkOutput("undo_pre_side", active_side, 32'd1);
    q1.push_back({6'h2B, 2'b00});
    btn_undo = 1'b1; tick(8); btn_undo = 1'b0; tick(4);
    checkOutput("undo_side", active_side, 32'd0);
    checkOutput("undo_state", state_o, 32'd3);
    btn_undo = 1'b1; tick(8); btn_undo = 1'b0; tick(4);
    checkOutput("second_undo_side", active_side, 32'd0);
    checkOutput("second_undo_state", state_o, 32'd3);
`endif

    tick(2);
    checkOutput("queue_empty", q1.size(), 32'd0);
    checkOutput("judge_start_count", jsSeen, jsExpected);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
